// File: rtl/bfp_mantissa_align.sv
`default_nettype none
// ============================================================================
// bfp_mantissa_align: aligns mantissas to the beat's shared exponent, output FIFO
// Rev 1.0
// ============================================================================
module bfp_mantissa_align #(
    parameter int V     = 8,
    parameter int P     = 8,
    parameter int BIT   = 32,
    parameter int FPM   = 23,
    parameter int BFPM  = 4,
    parameter int DEPTH = 4,
    localparam int EXP  = BIT - FPM - 1,
    localparam int MW   = BFPM + 2,
    localparam int EW   = BFPM + EXP + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [P*EW-1:0]   in_vect,
    input  logic [EXP-1:0]    in_exp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P*MW-1:0]   out_mant,
    output logic [EXP-1:0]    out_exp,
    output logic              out_last,
    output logic              overflow
);

    localparam int NBEATS = V / P;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int AW     = $clog2(DEPTH);
    localparam int FW     = P*MW + EXP + 1;
    localparam int MAGW   = BFPM + 1;
    localparam logic [EXP-1:0] ZEXP      = EXP'((1 << EXP) - (1 << (EXP-1)) + 1);
    localparam logic [CW-1:0]  LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [AW:0]    FULL_CNT  = (AW+1)'(DEPTH);

    logic [CW-1:0]     beat_cnt;
    logic              beat_last;

    logic [P*MAGW-1:0] mag_d;
    logic [P-1:0]      sign_d;
    logic [P-1:0]      neg_d;

    logic              s1_valid;
    logic              s1_last;
    logic [EXP-1:0]    s1_exp;
    logic [P*MAGW-1:0] s1_mag;
    logic [P-1:0]      s1_sign;
    logic [P*MW-1:0]   conv;

    logic [FW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              full;
    logic              push;
    logic              pop;
    logic              drop;
    logic [FW-1:0]     head;

    assign beat_last = (beat_cnt == LAST_BEAT);

    generate
        for (genvar i = 0; i < P; i++) begin : g_elem
            logic [EXP-1:0]  e;
            logic [BFPM-1:0] m;
            logic [EXP:0]    diff;
            logic [MAGW-1:0] whole;
            logic            zero;
            logic [MW-1:0]   ext;

            assign e     = in_vect[i*EW + BFPM +: EXP];
            assign m     = in_vect[i*EW +: BFPM];
            assign diff  = {1'b0, in_exp} - {1'b0, e};
            assign whole = {1'b1, m};
            assign zero  = (e == ZEXP);

            // A shift amount past the mantissa width naturally yields zero.
            assign mag_d[i*MAGW +: MAGW] = zero    ? '0 :
                                           diff[EXP] ? whole : (whole >> diff);
            assign sign_d[i] = in_vect[i*EW + EW - 1];
            assign neg_d[i]  = diff[EXP] & ~zero;

            assign ext = {1'b0, s1_mag[i*MAGW +: MAGW]};
            assign conv[i*MW +: MW] = s1_sign[i] ? (~ext + MW'(1)) : ext;
        end
    endgenerate

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid & out_ready;
    assign push      = s1_valid & (~full | pop);
    assign drop      = s1_valid & full & ~pop;

    assign head      = mem[rd_ptr];
    assign out_mant  = head[FW-1 -: P*MW];
    assign out_exp   = head[EXP:1];
    assign out_last  = out_valid & head[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            beat_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                beat_cnt <= beat_last ? '0 : beat_cnt + CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if ((in_valid && (|neg_d)) || drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            s1_mag  <= mag_d;
            s1_sign <= sign_d;
            s1_exp  <= in_exp;
            s1_last <= beat_last;
        end
        if (push) begin
            mem[wr_ptr] <= {conv, s1_exp, s1_last};
        end
    end

endmodule
`default_nettype wire
